uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/tx_fifo.sv | 62 ++++++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing derivation,
// used by both the transmit and receive sides.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned FRAME_BITS = 32'd10;

    function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return clock_hz / baud;
    endfunction

    function automatic logic is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit byte buffer. A push while full is dropped even if a pop happens
// on the same edge; a push and pop together leave the count unchanged.
module tx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == {CW{1'b0}});
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1'b1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1'b1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1'b1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1'b1);
            end
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter. Frames are sent back to back while the
// buffer holds data; the line idles high.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_HZ   = 100000000,
    parameter int BAUD       = 128000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         iFpgaClock,
    input  logic                         iFpgaReset,
    input  logic [7:0]                   iData,
    input  logic                         iValid,
    output logic                         oReady,
    output logic                         oTx,
    output logic                         oBusy,
    output logic [$clog2(FIFO_DEPTH):0]  oFifoCount
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if ((CLKS_PER_BIT < 2) || (FIFO_DEPTH < 2) || !is_pow2(FIFO_DEPTH)) begin : g_bad_cfg
            $error("uart_tx: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH a power of two >= 2");
        end
    endgenerate

    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tx;
    logic             pop;
    logic             bit_done;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (iFpgaClock),
        .rst   (iFpgaReset),
        .push  (iValid),
        .pop   (pop),
        .wdata (iData),
        .rdata (fifo_rdata),
        .count (oFifoCount),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_done = (cnt == CNT_LAST);

    // Pop the head byte exactly when a new frame begins
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && (state == ST_IDLE)) begin
            pop = 1'b1;
        end else if (!fifo_empty && (state == ST_STOP) && bit_done) begin
            pop = 1'b1;
        end else begin
            pop = 1'b0;
        end
    end

    // Frame sequencer; tx is registered so the line never glitches
    always_ff @(posedge iFpgaClock or posedge iFpgaReset) begin
        if (iFpgaReset) begin
            state   <= ST_IDLE;
            cnt     <= {CNT_W{1'b0}};
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            tx      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= {CNT_W{1'b0}};
                    if (pop) begin
                        state <= ST_START;
                        shreg <= fifo_rdata;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state   <= ST_DATA;
                        cnt     <= {CNT_W{1'b0}};
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1'b1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        cnt <= {CNT_W{1'b0}};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1'b1);
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        cnt <= {CNT_W{1'b0}};
                        if (pop) begin
                            state <= ST_START;
                            shreg <= fifo_rdata;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1'b1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= {CNT_W{1'b0}};
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign oTx    = tx;
    assign oReady = !fifo_full;
    assign oBusy  = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed bench for uart_tx, checked every cycle against a
// frame-timing model plus an independent 8N1 line receiver.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] acc_log[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_byte;
    logic [7:0] rx_b;
    int         m_start  = 0;
    bit         m_active = 1'b0;
    int         cyc      = 0;
    bit         log_en   = 1'b0;
    bit         rx_en    = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLOCK_HZ   (400),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .iFpgaClock (clk),
        .iFpgaReset (rst),
        .iData      (data),
        .iValid     (valid),
        .oReady     (ready),
        .oTx        (tx),
        .oBusy      (busy),
        .oFifoCount (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line level implied by the frame currently on the wire
    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (cyc - m_start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        int  pre_size;
        bit  do_pop;
        valid = v;
        data  = d;
        @(posedge clk);
        cyc++;
        pre_size = mq.size();
        do_pop   = (pre_size > 0) && (!m_active || (cyc == m_start + FRAME));
        if (m_active && (cyc == m_start + FRAME) && !do_pop) m_active = 1'b0;
        if (v && (pre_size < DEPTH)) begin
            mq.push_back(d);
            if (log_en) acc_log.push_back(d);
        end
        if (do_pop) begin
            m_byte   = mq.pop_front();
            m_start  = cyc;
            m_active = 1'b1;
        end
        #1;
        chk("tx",    {31'd0, tx},    {31'd0, exp_tx()});
        chk("busy",  {31'd0, busy},  {31'd0, (m_active || (mq.size() != 0))});
        chk("count", {29'd0, count}, mq.size());
        chk("ready", {31'd0, ready}, {31'd0, (mq.size() < DEPTH)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_tx",    {31'd0, tx},    32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        mq.delete();
        m_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Independent receiver: samples mid-bit once a start edge is seen
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && (tx === 1'b0)) begin
                repeat (CPB / 2) @(negedge clk);
                chk("rx_start", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("rx_stop", {31'd0, tx}, 32'd1);
                rx_q.push_back(rx_b);
            end
        end
    end

    initial begin
        int guard;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        #12;
        chk("init_tx",    {31'd0, tx},    32'd1);
        chk("init_busy",  {31'd0, busy},  32'd0);
        chk("init_count", {29'd0, count}, 32'd0);
        chk("init_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single 0xA5 frame accepted on the first edge after release
        step(1'b1, 8'hA5);
        chk("first_accept", {29'd0, count}, 32'd1);
        idle(FRAME + 5);

        // Back-to-back frames queued behind a running one
        step(1'b1, 8'h5A);
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle(3 * FRAME + 5);

        // Overfill a depth-4 buffer with valid held high
        for (int i = 0; i < 6; i++) step(1'b1, 8'h11 + 8'(i));
        idle(6 * FRAME);

        // Push on the same edge as a pop with three bytes queued
        for (int i = 0; i < 4; i++) step(1'b1, 8'h21 + 8'(i));
        guard = 0;
        while ((cyc + 1 != m_start + FRAME) && (guard < 2 * FRAME)) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("pushpop_pre", {29'd0, count}, 32'd3);
        step(1'b1, 8'h25);
        chk("pushpop_count", {29'd0, count}, 32'd3);
        idle(5 * FRAME);

        // Reset during bit 3 of 0x3C with two bytes queued
        step(1'b1, 8'h3C);
        step(1'b1, 8'h41);
        step(1'b1, 8'h42);
        guard = 0;
        while ((cyc - m_start != 4 * CPB + 1) && (guard < FRAME)) begin
            step(1'b0, 8'h00);
            guard++;
        end
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 8'h00);
            chk("quiet_line", {31'd0, tx}, 32'd1);
        end

        // Reset during a low start bit
        step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        apply_reset();
        idle(50);

        // Random traffic decoded by the line receiver
        rx_en  = 1'b1;
        log_en = 1'b1;
        guard  = 0;
        while ((acc_log.size() < 20) && (guard < 20000)) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            guard++;
        end
        log_en = 1'b0;
        guard  = 0;
        while ((m_active || (mq.size() != 0)) && (guard < 30 * FRAME)) begin
            step(1'b0, 8'h00);
            guard++;
        end
        chk("drain_done", {31'd0, (m_active || (mq.size() != 0))}, 32'd0);
        idle(10);
        rx_en = 1'b0;
        chk("rx_count", rx_q.size(), 32'd20);
        for (int i = 0; i < acc_log.size(); i++) begin
            chk("rx_byte", {24'd0, (i < rx_q.size()) ? rx_q[i] : 8'hxx}, {24'd0, acc_log[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
